// File: rtl/ex_stage.sv
// Execute stage: ALU, HI/LO registers, and an iterative restoring divider
// that holds the pipeline through stallreq_o while it runs.
//
// Divider states:
//   state      | meaning
//   S_IDLE     | no divide in flight; a presented DIV/DIVU starts one
//   S_DIV_ZERO | divisor was zero; quotient/remainder forced to 0
//   S_DIV_ON   | one quotient bit per cycle, DIV_CYCLES cycles
//   S_DIV_END  | sign fixup, HI/LO written, wait for pipeline to advance
module ex_stage #(
    parameter int DIV_CYCLES = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  aluop_i,
    input  logic [2:0]  alusel_i,
    input  logic [31:0] reg1_i,
    input  logic [31:0] reg2_i,
    input  logic [4:0]  wd_i,
    input  logic        wreg_i,
    input  logic        stall_i,
    input  logic        annul_i,
    output logic [4:0]  wd_o,
    output logic        wreg_o,
    output logic [31:0] wdata_o,
    output logic        stallreq_o
);
    localparam logic [7:0] OP_OR    = 8'h25, OP_AND  = 8'h24, OP_XOR   = 8'h26, OP_NOR = 8'h27;
    localparam logic [7:0] OP_ADD   = 8'h20, OP_ADDU = 8'h21, OP_SUB   = 8'h22, OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT   = 8'h2A, OP_SLTU = 8'h2B;
    localparam logic [7:0] OP_SLL   = 8'h7C, OP_SRL  = 8'h02, OP_SRA   = 8'h03;
    localparam logic [7:0] OP_MULT  = 8'h18, OP_MULTU = 8'h19, OP_DIV  = 8'h1A, OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_MFHI  = 8'h10, OP_MFLO = 8'h12;

    localparam logic [2:0] SEL_LOGIC = 3'd1, SEL_SHIFT = 3'd2, SEL_ARITH = 3'd3;
    localparam logic [2:0] SEL_MOVE  = 3'd4, SEL_HILO  = 3'd5;

    localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;

    typedef enum logic [1:0] {S_IDLE, S_DIV_ZERO, S_DIV_ON, S_DIV_END} div_state_e;

    div_state_e    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [31:0]   rem_q, rem_d, quo_q, quo_d, dsor_q, dsor_d;
    logic [31:0]   hi_q, hi_d, lo_q, lo_d;
    logic          neg_quo_q, neg_quo_d, neg_rem_q, neg_rem_d;
    logic          stallreq, div_wr;

    logic          is_sdiv, is_div, is_mult;
    logic [31:0]   abs1, abs2, quo_fix, rem_fix, sum, sub;
    logic [32:0]   trial, diff;
    logic [63:0]   prod;
    logic          ovf_add, ovf_sub;

    assign is_sdiv = (aluop_i == OP_DIV);
    assign is_div  = is_sdiv || (aluop_i == OP_DIVU);
    assign is_mult = (aluop_i == OP_MULT) || (aluop_i == OP_MULTU);

    // Divider works on magnitudes; signs are restored in S_DIV_END.
    assign abs1    = (is_sdiv && reg1_i[31]) ? (~reg1_i + 32'd1) : reg1_i;
    assign abs2    = (is_sdiv && reg2_i[31]) ? (~reg2_i + 32'd1) : reg2_i;
    assign trial   = {rem_q, quo_q[31]};
    assign diff    = trial - {1'b0, dsor_q};
    assign quo_fix = neg_quo_q ? (~quo_q + 32'd1) : quo_q;
    assign rem_fix = neg_rem_q ? (~rem_q + 32'd1) : rem_q;

    // Low 64 bits of the sign-extended product equal the signed product.
    assign prod = (aluop_i == OP_MULT) ?
                  ({{32{reg1_i[31]}}, reg1_i} * {{32{reg2_i[31]}}, reg2_i}) :
                  ({32'd0, reg1_i} * {32'd0, reg2_i});

    assign sum     = reg1_i + reg2_i;
    assign sub     = reg1_i - reg2_i;
    assign ovf_add = (reg1_i[31] == reg2_i[31]) && (sum[31] != reg1_i[31]);
    assign ovf_sub = (reg1_i[31] != reg2_i[31]) && (sub[31] != reg1_i[31]);

    // Divider next state, datapath step and stall request.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rem_d     = rem_q;
        quo_d     = quo_q;
        dsor_d    = dsor_q;
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
        stallreq  = 1'b0;
        div_wr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (is_div) begin
                    stallreq  = 1'b1;
                    quo_d     = abs1;
                    dsor_d    = abs2;
                    rem_d     = '0;
                    cnt_d     = '0;
                    neg_quo_d = is_sdiv && (reg1_i[31] ^ reg2_i[31]);
                    neg_rem_d = is_sdiv && reg1_i[31];
                    state_d   = (reg2_i == 32'd0) ? S_DIV_ZERO : S_DIV_ON;
                end
            end
            S_DIV_ZERO: begin
                stallreq  = 1'b1;
                quo_d     = '0;
                rem_d     = '0;
                neg_quo_d = 1'b0;
                neg_rem_d = 1'b0;
                state_d   = S_DIV_END;
            end
            S_DIV_ON: begin
                stallreq = 1'b1;
                if (!diff[32]) begin
                    rem_d = diff[31:0];
                    quo_d = {quo_q[30:0], 1'b1};
                end else begin
                    rem_d = trial[31:0];
                    quo_d = {quo_q[30:0], 1'b0};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(DIV_CYCLES - 1)) begin
                    state_d = S_DIV_END;
                end
            end
            S_DIV_END: begin
                div_wr = 1'b1;
                // Hold here while stalled so the same DIV is not restarted.
                if (!stall_i) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (annul_i) begin
            state_d  = S_IDLE;
            stallreq = 1'b0;
            div_wr   = 1'b0;
        end
    end

    // HI/LO update from divider completion or an unstalled multiply.
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (div_wr) begin
            hi_d = rem_fix;
            lo_d = quo_fix;
        end else if (is_mult && !stall_i) begin
            hi_d = prod[63:32];
            lo_d = prod[31:0];
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            dsor_q    <= '0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rem_q     <= rem_d;
            quo_q     <= quo_d;
            dsor_q    <= dsor_d;
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Combinational result so decode can forward it in the same cycle.
    always_comb begin
        wd_o       = '0;
        wreg_o     = 1'b0;
        wdata_o    = '0;
        stallreq_o = 1'b0;
        if (!rst) begin
            wd_o       = wd_i;
            wreg_o     = wreg_i;
            stallreq_o = stallreq;
            case (alusel_i)
                SEL_LOGIC: begin
                    case (aluop_i)
                        OP_OR:   wdata_o = reg1_i | reg2_i;
                        OP_AND:  wdata_o = reg1_i & reg2_i;
                        OP_XOR:  wdata_o = reg1_i ^ reg2_i;
                        OP_NOR:  wdata_o = ~(reg1_i | reg2_i);
                        default: wdata_o = '0;
                    endcase
                end
                SEL_SHIFT: begin
                    case (aluop_i)
                        OP_SLL:  wdata_o = reg2_i << reg1_i[4:0];
                        OP_SRL:  wdata_o = reg2_i >> reg1_i[4:0];
                        OP_SRA:  wdata_o = $signed(reg2_i) >>> reg1_i[4:0];
                        default: wdata_o = '0;
                    endcase
                end
                SEL_ARITH: begin
                    case (aluop_i)
                        OP_ADD, OP_ADDU: wdata_o = sum;
                        OP_SUB, OP_SUBU: wdata_o = sub;
                        OP_SLT:  wdata_o = {31'd0, ($signed(reg1_i) < $signed(reg2_i))};
                        OP_SLTU: wdata_o = {31'd0, (reg1_i < reg2_i)};
                        default: wdata_o = '0;
                    endcase
                    if (((aluop_i == OP_ADD) && ovf_add) || ((aluop_i == OP_SUB) && ovf_sub)) begin
                        wreg_o = 1'b0;
                    end
                end
                SEL_MOVE: begin
                    case (aluop_i)
                        OP_MFHI: wdata_o = hi_q;
                        OP_MFLO: wdata_o = lo_q;
                        default: wdata_o = '0;
                    endcase
                end
                SEL_HILO: wreg_o = 1'b0;
                default: wdata_o = '0;
            endcase
        end
    end
endmodule

// File: tb/tb_ex_stage.sv
// Bench for ex_stage: directed cases with literal expectations plus
// randomized instructions checked every cycle against a behavioural model.
module tb_ex_stage;
    localparam logic [7:0] OP_NOP = 8'h00, OP_OR = 8'h25, OP_AND = 8'h24, OP_XOR = 8'h26, OP_NOR = 8'h27;
    localparam logic [7:0] OP_ADD = 8'h20, OP_ADDU = 8'h21, OP_SUB = 8'h22, OP_SUBU = 8'h23;
    localparam logic [7:0] OP_SLT = 8'h2A, OP_SLTU = 8'h2B, OP_SLL = 8'h7C, OP_SRL = 8'h02, OP_SRA = 8'h03;
    localparam logic [7:0] OP_MULT = 8'h18, OP_MULTU = 8'h19, OP_DIV = 8'h1A, OP_DIVU = 8'h1B;
    localparam logic [7:0] OP_MFHI = 8'h10, OP_MFLO = 8'h12;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  aluop_i = '0;
    logic [2:0]  alusel_i = '0;
    logic [31:0] reg1_i = '0, reg2_i = '0;
    logic [4:0]  wd_i = '0;
    logic        wreg_i = 1'b0, stall_i = 1'b0, annul_i = 1'b0;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;
    logic        stallreq_o;

    always #5 clk = ~clk;

    ex_stage #(.DIV_CYCLES(32)) dut (
        .clk(clk), .rst(rst), .aluop_i(aluop_i), .alusel_i(alusel_i),
        .reg1_i(reg1_i), .reg2_i(reg2_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .stall_i(stall_i), .annul_i(annul_i), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o), .stallreq_o(stallreq_o)
    );

    int vectors = 0;
    int miscompares = 0;

    function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // ---------------- behavioural model ----------------
    logic [31:0] m_hi = '0, m_lo = '0, m_q = '0, m_r = '0;
    bit          m_busy = 1'b0;
    int          m_left = 0;

    function automatic bit op_is_div(input logic [7:0] op);
        return (op == OP_DIV) || (op == OP_DIVU);
    endfunction

    function automatic void model_out(output logic [31:0] wdata, output logic wreg);
        longint a_s, b_s, r;
        longint unsigned a_u, b_u;
        int sh;
        a_s = longint'($signed(reg1_i));
        b_s = longint'($signed(reg2_i));
        a_u = {32'd0, reg1_i};
        b_u = {32'd0, reg2_i};
        sh  = int'(reg1_i[4:0]);
        wdata = '0;
        wreg  = wreg_i;
        case (alusel_i)
            3'd1: case (aluop_i)
                OP_OR:  wdata = reg1_i | reg2_i;
                OP_AND: wdata = reg1_i & reg2_i;
                OP_XOR: wdata = reg1_i ^ reg2_i;
                OP_NOR: wdata = ~(reg1_i | reg2_i);
                default: wdata = '0;
            endcase
            3'd2: case (aluop_i)
                OP_SLL: begin a_u = b_u << sh; wdata = a_u[31:0]; end
                OP_SRL: wdata = reg2_i >> sh;
                OP_SRA: wdata = (reg2_i >> sh) | (reg2_i[31] ? ~(32'hFFFF_FFFF >> sh) : 32'd0);
                default: wdata = '0;
            endcase
            3'd3: begin
                r = 0;
                case (aluop_i)
                    OP_ADD, OP_ADDU: r = a_s + b_s;
                    OP_SUB, OP_SUBU: r = a_s - b_s;
                    OP_SLT:  r = (a_s < b_s) ? 1 : 0;
                    OP_SLTU: r = (a_u < b_u) ? 1 : 0;
                    default: r = 0;
                endcase
                wdata = r[31:0];
                if ((aluop_i == OP_ADD || aluop_i == OP_SUB) && (r > 64'sd2147483647 || r < -64'sd2147483648))
                    wreg = 1'b0;
            end
            3'd4: wdata = (aluop_i == OP_MFHI) ? m_hi : (aluop_i == OP_MFLO) ? m_lo : 32'd0;
            3'd5: wreg = 1'b0;
            default: wdata = '0;
        endcase
    endfunction

    // Model state advances on the same edge as the DUT.
    always @(posedge clk) begin : model_step
        longint a_s, b_s, q, r;
        longint unsigned pu;
        if (rst) begin
            m_hi = '0; m_lo = '0; m_busy = 1'b0; m_left = 0;
        end else begin
            if (m_busy && !annul_i && m_left == 0) begin
                m_hi = m_r; m_lo = m_q;
            end
            if (!m_busy && !stall_i && (aluop_i == OP_MULT || aluop_i == OP_MULTU)) begin
                if (aluop_i == OP_MULT) begin
                    q = longint'($signed(reg1_i)) * longint'($signed(reg2_i));
                    {m_hi, m_lo} = q;
                end else begin
                    pu = longint'({32'd0, reg1_i}) * longint'({32'd0, reg2_i});
                    {m_hi, m_lo} = pu;
                end
            end
            if (annul_i) begin
                m_busy = 1'b0;
            end else if (!m_busy) begin
                if (op_is_div(aluop_i)) begin
                    m_busy = 1'b1;
                    m_left = (reg2_i == 32'd0) ? 1 : 32;
                    if (reg2_i == 32'd0) begin
                        m_q = '0; m_r = '0;
                    end else begin
                        a_s = (aluop_i == OP_DIV) ? longint'($signed(reg1_i)) : longint'({32'd0, reg1_i});
                        b_s = (aluop_i == OP_DIV) ? longint'($signed(reg2_i)) : longint'({32'd0, reg2_i});
                        q = a_s / b_s;
                        r = a_s % b_s;
                        m_q = q[31:0];
                        m_r = r[31:0];
                    end
                end
            end else if (m_left > 0) begin
                m_left--;
            end else if (!stall_i) begin
                m_busy = 1'b0;
            end
        end
    end

    // Every-cycle comparison against the model, mid-cycle.
    always @(negedge clk) begin : compare
        logic [31:0] ew;
        logic er, es;
        logic [4:0] ed;
        model_out(ew, er);
        es = !annul_i && (m_busy ? (m_left > 0) : op_is_div(aluop_i));
        ed = wd_i;
        if (rst) begin
            ew = '0; er = 1'b0; es = 1'b0; ed = '0;
        end
        chk("m_wd", {27'd0, wd_o}, {27'd0, ed});
        chk("m_wreg", {31'd0, wreg_o}, {31'd0, er});
        chk("m_stallreq", {31'd0, stallreq_o}, {31'd0, es});
        if (rst || alusel_i != 3'd5)
            chk("m_wdata", wdata_o, ew);
    end

    // ---------------- stimulus ----------------
    task automatic issue(input logic [7:0] op, input logic [2:0] sel, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wd, input logic wr,
                         input logic stl, input int annul_at, output int nst);
        @(posedge clk); #1;
        aluop_i = op; alusel_i = sel; reg1_i = a; reg2_i = b; wd_i = wd; wreg_i = wr;
        stall_i = stl; annul_i = (annul_at == 0);
        nst = 0;
        for (int c = 0; c < 200; c++) begin
            @(negedge clk);
            if (annul_i || stallreq_o !== 1'b1) return;
            nst++;
            if (nst > 100) begin
                vectors++; miscompares++;
                $display("FAIL stall_timeout: stallreq still %b after %0d cycles, expected release by 34", stallreq_o, nst);
                return;
            end
            @(posedge clk); #1;
            annul_i = (annul_at == c + 1);
        end
    endtask

    function automatic logic [31:0] rnd_val();
        logic [31:0] sp[5];
        sp = '{32'd0, 32'd1, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF};
        if ($urandom_range(0, 3) == 0) return sp[$urandom_range(0, 4)];
        if ($urandom_range(0, 3) == 0) return 32'($urandom_range(0, 40));
        return $urandom;
    endfunction

    logic [7:0] op_tab[20];
    logic [2:0] sel_tab[20];

    initial begin
        int n;
        op_tab  = '{OP_NOP, OP_OR, OP_AND, OP_XOR, OP_NOR, OP_ADD, OP_ADDU, OP_SUB, OP_SUBU, OP_SLT,
                    OP_SLTU, OP_SLL, OP_SRL, OP_SRA, OP_MULT, OP_MULTU, OP_DIV, OP_DIVU, OP_MFHI, OP_MFLO};
        sel_tab = '{3'd0, 3'd1, 3'd1, 3'd1, 3'd1, 3'd3, 3'd3, 3'd3, 3'd3, 3'd3,
                    3'd3, 3'd2, 3'd2, 3'd2, 3'd5, 3'd5, 3'd5, 3'd5, 3'd4, 3'd4};

        // Reset: outputs forced to zero even with a live instruction presented.
        aluop_i = OP_OR; alusel_i = 3'd1; reg1_i = 32'h0000_F0F0; reg2_i = 32'h0000_0F0F;
        wd_i = 5'd5; wreg_i = 1'b1;
        repeat (3) @(negedge clk);
        chk("rst_wdata", wdata_o, 32'd0);
        chk("rst_wreg", {31'd0, wreg_o}, 32'd0);
        chk("rst_wd", {27'd0, wd_o}, 32'd0);
        @(posedge clk); #1 rst = 1'b0;

        issue(OP_MFHI, 3'd4, 0, 0, 5'd1, 1, 0, -1, n);
        chk("hi_after_rst", wdata_o, 32'd0);

        issue(OP_OR, 3'd1, 32'h0000_F0F0, 32'h0000_0F0F, 5'd5, 1, 0, -1, n);
        chk("or_wdata", wdata_o, 32'h0000_FFFF);
        chk("or_wreg", {31'd0, wreg_o}, 32'd1);
        chk("or_wd", {27'd0, wd_o}, 32'd5);

        issue(OP_ADD, 3'd3, 32'h7FFF_FFFF, 32'd1, 5'd3, 1, 0, -1, n);
        chk("add_ovf_wdata", wdata_o, 32'h8000_0000);
        chk("add_ovf_wreg", {31'd0, wreg_o}, 32'd0);
        issue(OP_ADDU, 3'd3, 32'h7FFF_FFFF, 32'd1, 5'd3, 1, 0, -1, n);
        chk("addu_wreg", {31'd0, wreg_o}, 32'd1);
        issue(OP_SRA, 3'd2, 32'd4, 32'h8000_0000, 5'd3, 1, 0, -1, n);
        chk("sra", wdata_o, 32'hF800_0000);

        issue(OP_MULT, 3'd5, 32'hFFFF_FFFD, 32'd7, 5'd0, 0, 0, -1, n);
        issue(OP_MFHI, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("mult_hi", wdata_o, 32'hFFFF_FFFF);
        issue(OP_MFLO, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("mult_lo", wdata_o, 32'hFFFF_FFEB);
        issue(OP_MULT, 3'd5, 32'd2, 32'd3, 5'd0, 0, 1, -1, n);
        issue(OP_MFLO, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("mult_stall_lo", wdata_o, 32'hFFFF_FFEB);

        issue(OP_DIV, 3'd5, 32'hFFFF_FFEF, 32'd5, 5'd0, 0, 0, -1, n);
        chk("div_stall_cycles", 32'(n), 32'd33);
        issue(OP_MFLO, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("div_lo", wdata_o, 32'hFFFF_FFFD);
        issue(OP_MFHI, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("div_hi", wdata_o, 32'hFFFF_FFFE);

        issue(OP_DIVU, 3'd5, 32'd100, 32'd7, 5'd0, 0, 0, -1, n);
        issue(OP_MFLO, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("divu_lo", wdata_o, 32'd14);
        issue(OP_MFHI, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("divu_hi", wdata_o, 32'd2);

        issue(OP_DIV, 3'd5, 32'd5, 32'd0, 5'd0, 0, 0, -1, n);
        chk("div0_stall_cycles", 32'(n), 32'd2);
        issue(OP_MFHI, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("div0_hi", wdata_o, 32'd0);
        issue(OP_MFLO, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("div0_lo", wdata_o, 32'd0);

        // Annul at divide cycle 10 keeps the prior HI/LO.
        issue(OP_MULTU, 3'd5, 32'h1234_5678, 32'h10, 5'd0, 0, 0, -1, n);
        issue(OP_DIV, 3'd5, 32'hFFFF_FFEF, 32'd5, 5'd0, 0, 0, 10, n);
        chk("annul_stall_cycles", 32'(n), 32'd10);
        chk("annul_stallreq", {31'd0, stallreq_o}, 32'd0);
        issue(OP_NOP, 3'd0, 0, 0, 5'd0, 0, 0, -1, n);
        chk("annul_idle_stallreq", {31'd0, stallreq_o}, 32'd0);
        issue(OP_MFHI, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("annul_hi", wdata_o, 32'h0000_0001);
        issue(OP_MFLO, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("annul_lo", wdata_o, 32'h2345_6780);

        // Reset at divide cycle 10 clears HI/LO and idles the divider.
        @(posedge clk); #1;
        aluop_i = OP_DIV; alusel_i = 3'd5; reg1_i = 32'hFFFF_FFEF; reg2_i = 32'd5; wreg_i = 1'b0;
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_stallreq", {31'd0, stallreq_o}, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0; aluop_i = OP_NOP; alusel_i = 3'd0;
        @(negedge clk);
        chk("rst_idle_stallreq", {31'd0, stallreq_o}, 32'd0);
        issue(OP_MFHI, 3'd4, 0, 0, 5'd2, 1, 0, -1, n);
        chk("rst_mid_hi", wdata_o, 32'd0);

        // Randomized instruction stream.
        for (int i = 0; i < 400; i++) begin
            int k, an;
            logic stl;
            logic [31:0] b;
            k = $urandom_range(0, 19);
            b = rnd_val();
            if (op_is_div(op_tab[k]) && $urandom_range(0, 5) == 0) b = 32'd0;
            stl = (!op_is_div(op_tab[k]) && $urandom_range(0, 3) == 0);
            an = (op_is_div(op_tab[k]) && $urandom_range(0, 4) == 0) ? $urandom_range(0, 34) : -1;
            issue(op_tab[k], sel_tab[k], rnd_val(), b, 5'($urandom_range(0, 31)),
                  1'($urandom_range(0, 1)), stl, an, n);
        end

        @(posedge clk); #1;
        aluop_i = OP_NOP; alusel_i = 3'd0; stall_i = 1'b0; annul_i = 1'b0;
        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
